// File: rtl/add_tree_stream.sv
// Pipelined N-input adder tree with a first-word-fall-through output FIFO.
// Upstream credit counts FIFO entries plus sums still in flight in the tree.
module add_tree_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 6,
  parameter int SIGNED     = 0,
  parameter int FIFO_DEPTH = 8,
  localparam int LAT       = $clog2(NUM_IN),
  localparam int OUT_WIDTH = DATA_WIDTH + LAT,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [NUM_IN*DATA_WIDTH-1:0]   din,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [OUT_WIDTH-1:0]           dout,
  output logic [LW-1:0]                  level
);

  localparam int  AW = LW - 1;
  localparam int  CW = $clog2(FIFO_DEPTH + LAT + 1) + 1;
  localparam bit  SX = (SIGNED != 0);

  function automatic int terms(input int k);
    int n;
    n = NUM_IN;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  logic                 acc;
  logic                 push;
  logic                 pop;
  logic [OUT_WIDTH-1:0] push_data;
  logic [LAT-1:0]       vbits;
  logic [CW-1:0]        pipe_nxt;

  assign acc = valid_i & ready_o;

  // Level 0 is the raw operands; levels 1..LAT-1 are registered,
  // level LAT is the combinational final add feeding the FIFO.
  for (genvar k = 0; k <= LAT; k++) begin : g_lvl
    localparam int W = DATA_WIDTH + k;
    localparam int N = terms(k);
    logic [W-1:0] t [N];
    logic         vld;

    if (k == 0) begin : g_in
      for (genvar j = 0; j < N; j++) begin : g_op
        assign t[j] = din[j*DATA_WIDTH +: DATA_WIDTH];
      end
      assign vld = acc;
    end else begin : g_add
      localparam int NP = terms(k - 1);
      logic [W-1:0] s [N];

      for (genvar j = 0; j < N; j++) begin : g_t
        logic [W-2:0] a;
        assign a = g_lvl[k-1].t[2*j];
        if (2*j + 1 < NP) begin : g_pair
          logic [W-2:0] b;
          assign b = g_lvl[k-1].t[2*j+1];
          assign s[j] = {SX & a[W-2], a} + {SX & b[W-2], b};
        end else begin : g_pass
          assign s[j] = {SX & a[W-2], a};
        end
      end

      if (k < LAT) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
          if (rst) vld <= 1'b0;
          else     vld <= g_lvl[k-1].vld;
        end

        always_ff @(posedge clk) begin
          if (g_lvl[k-1].vld) t <= s;
        end
      end else begin : g_out
        assign t   = s;
        assign vld = g_lvl[k-1].vld;
      end
    end

    if (k < LAT) begin : g_vb
      assign vbits[k] = vld;
    end
  end

  assign push      = g_lvl[LAT].vld;
  assign push_data = g_lvl[LAT].t[0];

  // After the edge, levels 1..LAT-1 hold whatever levels 0..LAT-2 hold now.
  assign pipe_nxt = CW'($countones(vbits)) - CW'(vbits[LAT-1]);

  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        count;
  logic [LW-1:0]        level_nxt;

  assign valid_o   = (count != '0);
  assign pop       = valid_o & ready_i;
  assign level_nxt = count + LW'(push) - LW'(pop);
  assign level     = count;
  assign dout      = valid_o ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= level_nxt;
      ready_o <= (CW'(level_nxt) + pipe_nxt) < CW'(FIFO_DEPTH);
    end
  end

endmodule

// File: tb/tb_add_tree_stream.sv
// Self-checking bench for add_tree_stream: vector table, hand sequences
// and random traffic against a queue-based token model.
module tb_add_tree_stream;

  localparam int DW  = 32;
  localparam int N   = 6;
  localparam int LAT = 3;
  localparam int OW  = 35;
  localparam int D   = 8;
  localparam int LW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [N*DW-1:0] din = '0;
  logic          ready_o;
  logic          valid_o;
  logic [OW-1:0] dout;
  logic [LW-1:0] level;

  logic          valid_s = 1'b0;
  logic          ready_i_s = 1'b0;
  logic [39:0]   din_s = '0;
  logic          ready_o_s, valid_o_s, ready_o_u, valid_o_u;
  logic [10:0]   dout_s, dout_u;
  logic [3:0]    level_s, level_u;

  always #5 clk = ~clk;

  add_tree_stream dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .din(din), .valid_o(valid_o), .ready_i(ready_i),
    .dout(dout), .level(level)
  );

  add_tree_stream #(.DATA_WIDTH(8), .NUM_IN(5), .SIGNED(1), .FIFO_DEPTH(8)) u_s (
    .clk(clk), .rst(rst), .valid_i(valid_s), .ready_o(ready_o_s),
    .din(din_s), .valid_o(valid_o_s), .ready_i(ready_i_s),
    .dout(dout_s), .level(level_s)
  );

  add_tree_stream #(.DATA_WIDTH(8), .NUM_IN(5), .SIGNED(0), .FIFO_DEPTH(8)) u_u (
    .clk(clk), .rst(rst), .valid_i(valid_s), .ready_o(ready_o_u),
    .din(din_s), .valid_o(valid_o_u), .ready_i(ready_i_s),
    .dout(dout_u), .level(level_u)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit exp_ready = 1'b0;

  typedef struct {
    logic [OW-1:0] sum;
    int            due;
  } pend_t;

  pend_t         pend_q [$];
  logic [OW-1:0] fifo_q [$];

  typedef struct {
    logic [N*DW-1:0] d;
    logic [OW-1:0]   exp;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [OW-1:0] ref_sum(input logic [N*DW-1:0] d);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + {32'b0, d[i*DW +: DW]};
    return s[OW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [OW-1:0] h;
    h = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    chk("m_valid_o", 64'(valid_o), 64'(fifo_q.size() != 0));
    chk("m_dout",    64'(dout),    64'(h));
    chk("m_level",   64'(level),   64'(fifo_q.size()));
    chk("m_ready_o", 64'(ready_o), 64'(exp_ready));
  endtask

  task automatic cycle();
    bit    acc, pop;
    pend_t p;
    acc = valid_i && exp_ready;
    pop = (fifo_q.size() != 0) && ready_i;
    @(posedge clk);
    cyc++;
    if (pop) void'(fifo_q.pop_front());
    if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
      p = pend_q.pop_front();
      fifo_q.push_back(p.sum);
    end
    if (acc) begin
      p.sum = ref_sum(din);
      p.due = cyc + LAT - 1;
      pend_q.push_back(p);
    end
    exp_ready = (fifo_q.size() + pend_q.size()) < D;
    #1;
    check_model();
  endtask

  task automatic rand_din();
    for (int i = 0; i < N; i++) din[i*DW +: DW] = $urandom;
  endtask

  task automatic drain();
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int c = 0; c < 16; c++) cycle();
  endtask

  initial begin
    int  n_acc, nres, n, r, gaps, maxlvl;
    bit  got;

    tbl[0] = '{{6{32'd0}}, 35'd0};
    tbl[1] = '{{6{32'hFFFF_FFFF}}, 35'h5_FFFF_FFFA};
    tbl[2] = '{{32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd10}, 35'd210};
    tbl[3] = '{{6{32'h8000_0000}}, 35'h3_0000_0000};
    tbl[4] = '{{32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1}, 35'h8000_0000};
    tbl[5] = '{{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 35'd1};

    // reset state
    #12;
    chk("rst_ready_o", 64'(ready_o), 64'd0);
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_level",   64'(level),   64'd0);
    chk("rst_dout",    64'(dout),    64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("post_rst_ready_low", 64'(ready_o), 64'd0);
    cycle();
    chk("ready_after_edge", 64'(ready_o), 64'd1);

    // width / sign on 8-bit x5 instances
    din_s   = {5{8'h80}};
    valid_s = 1'b1;
    cycle();
    valid_s = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      if (valid_o_s && valid_o_u) got = 1'b1;
      else cycle();
    end
    chk("sign_seen",   64'(got),    64'd1);
    chk("signed_sum",  64'(dout_s), 64'h580);
    chk("unsign_sum",  64'(dout_u), 64'h280);
    chk("signed_lvl",  64'(level_s), 64'd1);

    // single sum with exact latency
    ready_i = 1'b0;
    din = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    valid_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    cycle();
    chk("single_e1_valid", 64'(valid_o), 64'd0);
    cycle();
    chk("single_valid", 64'(valid_o), 64'd1);
    chk("single_dout",  64'(dout),    64'd21);
    chk("single_level", 64'(level),   64'd1);
    ready_i = 1'b1;
    cycle();
    chk("single_pop_level", 64'(level),   64'd0);
    chk("single_pop_valid", 64'(valid_o), 64'd0);

    // vector table
    for (int i = 0; i < 6; i++) begin
      din = tbl[i].d;
      valid_i = 1'b1;
      cycle();
      valid_i = 1'b0;
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
        if (valid_o) begin
          chk($sformatf("tbl%0d_dout", i), 64'(dout), 64'(tbl[i].exp));
          got = 1'b1;
        end
        cycle();
      end
      chk($sformatf("tbl%0d_seen", i), 64'(got), 64'd1);
    end

    // backpressure fill
    ready_i = 1'b0;
    for (int i = 0; i < N; i++) din[i*DW +: DW] = 32'd1;
    valid_i = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 14; c++) begin
      if (ready_o) n_acc++;
      cycle();
    end
    valid_i = 1'b0;
    chk("bp_accepts", 64'(n_acc),   64'd8);
    chk("bp_level",   64'(level),   64'd8);
    chk("bp_ready",   64'(ready_o), 64'd0);
    ready_i = 1'b1;
    nres = 0;
    for (int c = 0; c < 12; c++) begin
      if (valid_o) begin
        chk("bp_dout", 64'(dout), 64'd6);
        nres++;
      end
      cycle();
      if (c == 0) chk("bp_reassert", 64'(ready_o), 64'd1);
    end
    chk("bp_results", 64'(nres), 64'd8);

    // back-to-back streaming
    n = 0; r = 0; gaps = 0;
    for (int c = 0; c < 40; c++) begin
      if (n < 20) begin
        valid_i = 1'b1;
        for (int i = 0; i < N; i++) din[i*DW +: DW] = DW'(n + i);
      end else begin
        valid_i = 1'b0;
      end
      if (valid_o) begin
        chk("stream_dout", 64'(dout), 64'(6 * r + 15));
        r++;
      end else if (r > 0 && r < 20) begin
        gaps++;
      end
      if (valid_i && ready_o) n++;
      cycle();
    end
    chk("stream_accepts", 64'(n),    64'd20);
    chk("stream_results", 64'(r),    64'd20);
    chk("stream_gaps",    64'(gaps), 64'd0);

    // full FIFO with consumer toggling
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      rand_din();
      cycle();
    end
    maxlvl = 0;
    for (int c = 0; c < 40; c++) begin
      ready_i = c[0];
      rand_din();
      cycle();
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    chk("toggle_max_ok", 64'(maxlvl <= D), 64'd1);
    drain();

    // random traffic
    for (int c = 0; c < 300; c++) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = ($urandom_range(0, 3) != 0);
      rand_din();
      cycle();
    end
    drain();
    chk("drain_level", 64'(level), 64'd0);

    // reset with 2 sums in the tree and 3 in the FIFO
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      rand_din();
      cycle();
    end
    valid_i = 1'b0;
    chk("pre_rst_level", 64'(level), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(valid_o), 64'd0);
    chk("mid_rst_level", 64'(level),   64'd0);
    chk("mid_rst_ready", 64'(ready_o), 64'd0);
    chk("mid_rst_dout",  64'(dout),    64'd0);
    pend_q.delete();
    fifo_q.delete();
    exp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rel_ready_low", 64'(ready_o), 64'd0);
    ready_i = 1'b1;
    for (int c = 0; c < 10; c++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
